// File: rtl/period_toggle_divider_if.sv
// period_toggle_divider_if: control, load handshake and status bundle for the toggle divider (carryOut present with PERIOD_TOGGLE_DIVIDER_CARRY_EN)
interface period_toggle_divider_if #(
  parameter int COUNT_WIDTH = 5
);
  logic                   enable;
  logic                   clear;
  logic                   loadValid;
  logic [COUNT_WIDTH-1:0] loadTerminal;
  logic                   loadReady;
  logic [COUNT_WIDTH-1:0] counterOut;
  logic                   clockOut;
  logic                   terminalPulse;
  logic [COUNT_WIDTH-1:0] activeTerminal;
`ifdef PERIOD_TOGGLE_DIVIDER_CARRY_EN
  logic                   carryOut;
  modport master (output enable, clear, loadValid, loadTerminal,
                  input loadReady, counterOut, clockOut, terminalPulse, activeTerminal, carryOut);
  modport slave  (input enable, clear, loadValid, loadTerminal,
                  output loadReady, counterOut, clockOut, terminalPulse, activeTerminal, carryOut);
`else
  modport master (output enable, clear, loadValid, loadTerminal,
                  input loadReady, counterOut, clockOut, terminalPulse, activeTerminal);
  modport slave  (input enable, clear, loadValid, loadTerminal,
                  output loadReady, counterOut, clockOut, terminalPulse, activeTerminal);
`endif
endinterface

// File: rtl/period_toggle_divider.sv
// period_toggle_divider: 50% duty toggle divider with runtime-loadable half-period (optional carryOut via PERIOD_TOGGLE_DIVIDER_CARRY_EN)
module period_toggle_divider #(
  parameter int COUNT_WIDTH = 5,
  parameter int TERMINAL    = 29,
  parameter int INIT_LEVEL  = 0
) (
  input logic clock,
  input logic reset,
  period_toggle_divider_if.slave bus
);
  localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(TERMINAL);
  localparam logic INIT = INIT_LEVEL != 0;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t                 state;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] active;
  logic [COUNT_WIDTH-1:0] shadow;
  logic                   level;
  logic                   pulse;
  logic                   carry;
  logic                   wrap;
  assign wrap = bus.enable && count == active;
  // Counter, toggle, load FSM and registered status in one place so a new terminal only lands on a wrap or clear
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      active <= TERM;
      shadow <= TERM;
      level  <= INIT;
      pulse  <= 1'b0;
      carry  <= 1'b0;
    end else if (bus.clear) begin
      count <= '0;
      level <= INIT;
      pulse <= 1'b0;
      carry <= 1'b0;
      state <= IDLE;
      if (state == PENDING)
        active <= shadow;
      else if (bus.loadValid)
        active <= bus.loadTerminal;
    end else begin
      pulse <= wrap;
      carry <= wrap && level != INIT;
      if (bus.enable) begin
        count <= wrap ? '0 : count + 1'b1;
        level <= wrap ? ~level : level;
      end
      if (state == IDLE && bus.loadValid) begin
        shadow <= bus.loadTerminal;
        state  <= PENDING;
      end else if (state == PENDING && wrap) begin
        active <= shadow;
        state  <= IDLE;
      end
    end
  end
  assign bus.loadReady      = state == IDLE;
  assign bus.counterOut     = count;
  assign bus.clockOut       = level;
  assign bus.terminalPulse  = pulse;
  assign bus.activeTerminal = active;
`ifdef PERIOD_TOGGLE_DIVIDER_CARRY_EN
  assign bus.carryOut = carry;
`else
  logic unused_carry;
  assign unused_carry = carry;
`endif
endmodule

// File: tb/tb_period_toggle_divider.sv
// tb_period_toggle_divider: directed and randomized checks of period_toggle_divider against a behavioural model
module tb_period_toggle_divider;
  localparam int W = 5;
  localparam int TERM = 29;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  period_toggle_divider_if #(.COUNT_WIDTH(W)) bus ();
  period_toggle_divider #(.COUNT_WIDTH(W), .TERMINAL(TERM), .INIT_LEVEL(0)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;

  int m_cnt, m_act, m_shadow;
  bit m_lvl, m_pulse, m_carry, m_pend, m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_act = TERM; m_lvl = 0; m_pulse = 0; m_carry = 0; m_pend = 0; m_valid = 1;
    end else if (bus.clear) begin
      if (m_pend) m_act = m_shadow;
      else if (bus.loadValid) m_act = int'(bus.loadTerminal);
      m_pend = 0; m_cnt = 0; m_lvl = 0; m_pulse = 0; m_carry = 0;
    end else begin
      bit was_pend, hit;
      was_pend = m_pend;
      hit = bus.enable && m_cnt == m_act;
      if (!was_pend && bus.loadValid) begin
        m_shadow = int'(bus.loadTerminal);
        m_pend = 1;
      end
      m_pulse = hit;
      m_carry = hit && m_lvl;
      if (hit) begin
        m_cnt = 0;
        m_lvl = !m_lvl;
        if (was_pend) begin
          m_act = m_shadow;
          m_pend = 0;
        end
      end else if (bus.enable) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("counterOut", int'(bus.counterOut), m_cnt);
      chk("clockOut", int'(bus.clockOut), int'(m_lvl));
      chk("terminalPulse", int'(bus.terminalPulse), int'(m_pulse));
      chk("activeTerminal", int'(bus.activeTerminal), m_act);
      chk("loadReady", int'(bus.loadReady), int'(!m_pend));
`ifdef PERIOD_TOGGLE_DIVIDER_CARRY_EN
      chk("carryOut", int'(bus.carryOut), int'(m_carry));
`endif
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    bus.enable = 0; bus.clear = 0; bus.loadValid = 0; bus.loadTerminal = '0;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (int'(bus.counterOut) != v && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) chk("wait_cnt_timeout", int'(bus.counterOut), v);
  endtask

  task automatic measure(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.terminalPulse && n < 200);
  endtask

  initial begin
    int np, first, n;
    do_reset();
    chk("reset_cnt", int'(bus.counterOut), 0);
    chk("reset_lvl", int'(bus.clockOut), 0);
    chk("reset_act", int'(bus.activeTerminal), TERM);
    chk("reset_ready", int'(bus.loadReady), 1);
    bus.enable = 1;
    np = 0;
    for (int k = 1; k <= 120; k++) begin
      cycle();
      if (k == 29) chk("cnt_at_29", int'(bus.counterOut), 29);
      if (bus.terminalPulse) begin
        np++;
        chk("pulse_cycle_mod30", k % 30, 0);
      end
    end
    chk("pulse_count_120", np, 4);
    chk("lvl_after_120", int'(bus.clockOut), 0);
    chk("cnt_after_120", int'(bus.counterOut), 0);

    do_reset();
    first = 0;
    for (int k = 1; k <= 62; k++) begin
      bus.enable = k[0];
      cycle();
      if (bus.terminalPulse && first == 0) first = k;
    end
    chk("gated_first_toggle", first, 59);

    do_reset();
    bus.enable = 1;
    wait_cnt(5);
    bus.loadValid = 1; bus.loadTerminal = 5'd9;
    cycle();
    bus.loadValid = 0;
    chk("load9_ready_low", int'(bus.loadReady), 0);
    measure(n);
    chk("load9_first_wrap", n, 24);
    chk("load9_active", int'(bus.activeTerminal), 9);
    chk("load9_ready_back", int'(bus.loadReady), 1);
    measure(n);
    chk("load9_half", n, 10);
    measure(n);
    chk("load9_half2", n, 10);

    do_reset();
    bus.enable = 1;
    wait_cnt(29);
    bus.loadValid = 1; bus.loadTerminal = 5'd3;
    cycle();
    bus.loadValid = 0;
    chk("wrapload_pulse", int'(bus.terminalPulse), 1);
    chk("wrapload_old_term", int'(bus.activeTerminal), 29);
    measure(n);
    chk("wrapload_half30", n, 30);
    chk("wrapload_active", int'(bus.activeTerminal), 3);
    measure(n);
    chk("wrapload_half4", n, 4);

    do_reset();
    bus.enable = 1;
    measure(n);
    bus.loadValid = 1; bus.loadTerminal = 5'd4;
    cycle();
    bus.loadValid = 0;
    wait_cnt(17);
    chk("clear_pre_lvl", int'(bus.clockOut), 1);
    bus.clear = 1;
    cycle();
    bus.clear = 0;
    chk("clear_cnt", int'(bus.counterOut), 0);
    chk("clear_lvl", int'(bus.clockOut), 0);
    chk("clear_act", int'(bus.activeTerminal), 4);
    measure(n);
    chk("clear_then_5", n, 5);

    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst = $urandom_range(0, 199) == 0;
      bus.enable = $urandom_range(0, 3) != 0;
      bus.clear = $urandom_range(0, 39) == 0;
      bus.loadValid = $urandom_range(0, 9) == 0;
      bus.loadTerminal = W'($urandom_range(0, 31));
      cycle();
    end
    rst = 0;
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
